// File: rtl/iob_timer_core_pkg.sv
// Shared constants for the IOb timer core and its CPU-facing wrapper.
//   DATA_W_DEFAULT : default CPU data width
//   TIMER_W        : counter / snapshot width for the default data width
package iob_timer_core_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned TIMER_W        = 2 * DATA_W_DEFAULT;

endpackage

// File: rtl/iob_timer_core_if.sv
// Control/readback signals between the timer register wrapper and the timer core.
//   TIMER_ENABLE : count enable (level)
//   TIMER_SAMPLE : snapshot strobe (level, sampled every cycle)
//   TIMER_VALUE  : last captured count (registered in the core)
// master = register wrapper, slave = timer core.
interface iob_timer_core_if #(
    parameter int unsigned DATA_W = 32
);

    logic                  TIMER_ENABLE;
    logic                  TIMER_SAMPLE;
    logic [2*DATA_W-1:0]   TIMER_VALUE;

    modport master (
        output TIMER_ENABLE,
        output TIMER_SAMPLE,
        input  TIMER_VALUE
    );

    modport slave (
        input  TIMER_ENABLE,
        input  TIMER_SAMPLE,
        output TIMER_VALUE
    );

endinterface

// File: rtl/iob_counter.sv
// Generic free-running up-counter with async active-high reset and enable.
// Wraps modulo 2^W with no saturation or overflow flag.
//   clk  : clock
//   rst  : async reset, clears the count
//   en   : increment on the rising edge when high, hold otherwise
//   data : current count
module iob_counter #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] data
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + W'(1);
        end
    end

    assign data = count_q;

endmodule

// File: rtl/iob_timer_core.sv
// IOb timer core: 2*DATA_W-bit cycle counter plus a snapshot register.
//   clk : clock
//   rst : async active-high reset, clears counter and snapshot
//   bus : slave side of iob_timer_core_if (enable, sample in; value out)
// The snapshot takes the pre-edge count, so an edge that both counts and
// samples captures the old value.
module iob_timer_core
    import iob_timer_core_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    iob_timer_core_if.slave     bus
);

    localparam int unsigned TimerW = 2 * DATA_W;

    logic [TimerW-1:0] count;
    logic [TimerW-1:0] value_q;

    iob_counter #(
        .W (TimerW)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.TIMER_ENABLE),
        .data (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else if (bus.TIMER_SAMPLE) begin
            value_q <= count;
        end
    end

    assign bus.TIMER_VALUE = value_q;

endmodule

// File: tb/tb_iob_timer_core.sv
// Directed bench for iob_timer_core: a default-width instance for timing,
// gating and reset, plus a DATA_W=2 (4-bit counter) instance for wrap-around.
module tb_iob_timer_core;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    iob_timer_core_if #(.DATA_W(32)) bus ();
    iob_timer_core_if #(.DATA_W(2))  sbus ();

    iob_timer_core #(
        .DATA_W (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    iob_timer_core #(
        .DATA_W (2)
    ) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs driven and outputs read here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_sample();
        bus.TIMER_SAMPLE = 1'b1;
        tick();
        bus.TIMER_SAMPLE = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1;
        bus.TIMER_ENABLE  = 1'b0;
        bus.TIMER_SAMPLE  = 1'b0;
        sbus.TIMER_ENABLE = 1'b0;
        sbus.TIMER_SAMPLE = 1'b0;

        // 1. Reset
        #2;
        check("reset_async", bus.TIMER_VALUE, 64'd0);
        repeat (3) tick();
        check("reset_held", bus.TIMER_VALUE, 64'd0);
        rst = 1'b0;
        tick();
        check("after_reset", bus.TIMER_VALUE, 64'd0);
        repeat (5) tick();
        pulse_sample();
        check("idle_sample", bus.TIMER_VALUE, 64'd0);

        // 2. Basic timing: enable just after E0, sample across E2 sees count 1
        bus.TIMER_ENABLE = 1'b1;
        tick();                       // E1: count 1
        pulse_sample();               // E2: capture 1, count 2
        check("basic_timing", bus.TIMER_VALUE, 64'd1);

        // 3. Long interval: bring count to 1003, then capture it
        repeat (1001) tick();         // count 1003
        pulse_sample();               // capture 1003, count 1004
        check("long_interval", bus.TIMER_VALUE, 64'd1003);
        bus.TIMER_ENABLE = 1'b0;

        // Async reset between edges clears the snapshot before any clock edge
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_mid", bus.TIMER_VALUE, 64'd0);
        rst = 1'b0;
        tick();

        // 4. Enable gating: 10 counted edges, then frozen
        bus.TIMER_ENABLE = 1'b1;
        repeat (10) tick();
        bus.TIMER_ENABLE = 1'b0;
        repeat (20) tick();
        pulse_sample();
        check("gated_sample", bus.TIMER_VALUE, 64'd10);
        repeat (5) tick();
        pulse_sample();
        check("gated_resample", bus.TIMER_VALUE, 64'd10);

        // 5. Sample held high with enable: snapshot trails the count by one
        bus.TIMER_ENABLE = 1'b1;
        bus.TIMER_SAMPLE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("held_sample_%0d", i), bus.TIMER_VALUE, 64'(10 + i));
        end
        bus.TIMER_SAMPLE = 1'b0;
        bus.TIMER_ENABLE = 1'b0;      // count now 14

        // 6. Wrap on 4-bit instance: reach 14 (2^4-2), then 3 more edges -> 1
        sbus.TIMER_ENABLE = 1'b1;
        repeat (14) tick();
        sbus.TIMER_SAMPLE = 1'b1;
        tick();                       // capture 14, count 15
        sbus.TIMER_SAMPLE = 1'b0;
        check("small_pre_wrap", 64'(sbus.TIMER_VALUE), 64'd14);
        repeat (2) tick();            // 15 -> 0 -> 1
        sbus.TIMER_ENABLE = 1'b0;
        sbus.TIMER_SAMPLE = 1'b1;
        tick();
        sbus.TIMER_SAMPLE = 1'b0;
        check("small_wrap", 64'(sbus.TIMER_VALUE), 64'd1);

        // Async reset pulse between edges clears both snapshots immediately
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_main", bus.TIMER_VALUE, 64'd0);
        check("async_reset_small", 64'(sbus.TIMER_VALUE), 64'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Counting resumes from 0 after reset
        bus.TIMER_ENABLE = 1'b1;
        tick();                       // count 1
        pulse_sample();               // capture 1
        check("resume_after_reset", bus.TIMER_VALUE, 64'd1);
        bus.TIMER_ENABLE = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
